issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_pkg.sv | 52 +++++
 rtl/issue_hazard_check.sv | 25 ++
 rtl/issue_scoreboard.sv | 177 +++++++++++++++++
 tb/tb_issue_scoreboard.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the dual-issue scoreboard: instruction classes,
// window/register-file dimensions and small mask/packing helpers.
package issue_scoreboard_pkg;

  localparam int WIN_DEPTH = 2;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_MEM    = 2'b10,
    CLS_CSR    = 2'b11
  } iclass_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic        we;
    iclass_e     cls;
  } instr_t;

  typedef struct packed {
    logic        valid;
    logic        older;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
  } iss_t;

  // One-hot register mask; x0 never produces a bit.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [4:0] rd, input logic en);
    return (en && (rd != 5'd0)) ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << rd) : {NUM_REGS{1'b0}};
  endfunction

  // Pipe1 for MEM, pipe0 for CSR/BRANCH, caller-chosen pipe for ALU.
  function automatic logic pick_pipe(input iclass_e cls, input logic alu_pipe);
    case (cls)
      CLS_MEM: return 1'b1;
      CLS_ALU: return alu_pipe;
      default: return 1'b0;
    endcase
  endfunction

  function automatic iss_t make_iss(input instr_t ins, input logic older);
    return '{valid: 1'b1, older: older, pc: ins.pc, rd: ins.rd, we: ins.we};
  endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Read/write hazard test of one instruction against the busy vector
// (busy is the pre-update value, so writebacks give no bypass).
module issue_hazard_check
  import issue_scoreboard_pkg::*;
(
  input  logic                use_rs1,
  input  logic [4:0]          rs1,
  input  logic                use_rs2,
  input  logic [4:0]          rs2,
  input  logic                we,
  input  logic [4:0]          rd,
  input  logic [NUM_REGS-1:0] busy,
  output logic                hazard_free
);

  logic rs1_hit_s;
  logic rs2_hit_s;
  logic rd_hit_s;

  assign rs1_hit_s   = use_rs1 && (rs1 != 5'd0) && busy[rs1];
  assign rs2_hit_s   = use_rs2 && (rs2 != 5'd0) && busy[rs2];
  assign rd_hit_s    = we && (rd != 5'd0) && busy[rd];
  assign hazard_free = !(rs1_hit_s || rs2_hit_s || rd_hit_s);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order dual-issue scoreboard: 2-entry window, busy-bit hazard tracking,
// registered issue to pipe0 (ALU/BRANCH/CSR) and pipe1 (ALU/MEM).
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stop,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1_pc,
  input  logic [4:0]  in1_rd,
  input  logic [4:0]  in1_rs1,
  input  logic [4:0]  in1_rs2,
  input  logic        in1_use_rs1,
  input  logic        in1_use_rs2,
  input  logic        in1_we,
  input  logic [1:0]  in1_class,
  input  logic [31:0] in2_pc,
  input  logic [4:0]  in2_rd,
  input  logic [4:0]  in2_rs1,
  input  logic [4:0]  in2_rs2,
  input  logic        in2_use_rs1,
  input  logic        in2_use_rs2,
  input  logic        in2_we,
  input  logic [1:0]  in2_class,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_rd,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_rd,
  output logic        iss0_valid,
  output logic [31:0] iss0_pc,
  output logic [4:0]  iss0_rd,
  output logic        iss0_we,
  output logic        iss1_valid,
  output logic [31:0] iss1_pc,
  output logic [4:0]  iss1_rd,
  output logic        iss1_we,
  output logic [3:0]  l_flag
);

  instr_t              win_r [WIN_DEPTH];
  logic [1:0]          count_r;
  logic [NUM_REGS-1:0] busy_r;
  iss_t                iss0_r;
  iss_t                iss1_r;

  instr_t              head_s;
  instr_t              next_s;
  instr_t              in1_s;
  instr_t              in2_s;
  logic                head_free_s;
  logic                next_free_s;
  logic                head_pipe_s;
  logic                next_pipe_s;
  logic                dep_s;
  logic                head_issue_s;
  logic                next_issue_s;
  logic                all_issue_s;
  logic                accept_s;
  logic [NUM_REGS-1:0] busy_nxt_s;
  iss_t                iss0_nxt_s;
  iss_t                iss1_nxt_s;

  assign head_s = win_r[0];
  assign next_s = win_r[1];

  assign in1_s = '{pc: in1_pc, rd: in1_rd, rs1: in1_rs1, rs2: in1_rs2, use_rs1: in1_use_rs1,
                   use_rs2: in1_use_rs2, we: in1_we, cls: iclass_e'(in1_class)};
  assign in2_s = '{pc: in2_pc, rd: in2_rd, rs1: in2_rs1, rs2: in2_rs2, use_rs1: in2_use_rs1,
                   use_rs2: in2_use_rs2, we: in2_we, cls: iclass_e'(in2_class)};

  issue_hazard_check u_head_chk (
    .use_rs1     (head_s.use_rs1),
    .rs1         (head_s.rs1),
    .use_rs2     (head_s.use_rs2),
    .rs2         (head_s.rs2),
    .we          (head_s.we),
    .rd          (head_s.rd),
    .busy        (busy_r),
    .hazard_free (head_free_s)
  );

  issue_hazard_check u_next_chk (
    .use_rs1     (next_s.use_rs1),
    .rs1         (next_s.rs1),
    .use_rs2     (next_s.use_rs2),
    .rs2         (next_s.rs2),
    .we          (next_s.we),
    .rd          (next_s.rd),
    .busy        (busy_r),
    .hazard_free (next_free_s)
  );

  // Busy does not yet contain the head's rd, so the pair dependency is checked directly.
  assign dep_s = head_s.we && (head_s.rd != 5'd0) &&
                 ((next_s.use_rs1 && (next_s.rs1 == head_s.rd)) ||
                  (next_s.use_rs2 && (next_s.rs2 == head_s.rd)) ||
                  (next_s.we      && (next_s.rd  == head_s.rd)));

  assign head_pipe_s  = pick_pipe(head_s.cls, 1'b0);
  assign next_pipe_s  = pick_pipe(next_s.cls, ~head_pipe_s);
  assign head_issue_s = !stop && (count_r != 2'd0) && head_free_s;
  assign next_issue_s = head_issue_s && (count_r == 2'd2) && next_free_s &&
                        (next_pipe_s != head_pipe_s) &&
                        (head_s.cls != CLS_CSR) && (next_s.cls != CLS_CSR) && !dep_s;

  assign all_issue_s = ((count_r == 2'd1) && head_issue_s) || ((count_r == 2'd2) && next_issue_s);
  assign in_ready    = !flush && ((count_r == 2'd0) || all_issue_s);
  assign accept_s    = in_valid && in_ready;

  // Clears first, then sets, so an issue-time set beats a same-cycle writeback.
  assign busy_nxt_s = (busy_r & ~(reg_mask(wb0_rd, wb0_valid) | reg_mask(wb1_rd, wb1_valid))) |
                      reg_mask(head_s.rd, head_issue_s && head_s.we) |
                      reg_mask(next_s.rd, next_issue_s && next_s.we);

  assign iss0_nxt_s = (head_issue_s && !head_pipe_s) ? make_iss(head_s, 1'b1) :
                      (next_issue_s && !next_pipe_s) ? make_iss(next_s, 1'b0) : '0;
  assign iss1_nxt_s = (head_issue_s &&  head_pipe_s) ? make_iss(head_s, 1'b1) :
                      (next_issue_s &&  next_pipe_s) ? make_iss(next_s, 1'b0) : '0;

  // Window and occupancy: accept, shift on single issue, drain on dual issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 2'd0;
      for (int i = 0; i < WIN_DEPTH; i++) win_r[i] <= '0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else if (accept_s) begin
      win_r[0] <= in1_s;
      win_r[1] <= in2_s;
      count_r  <= 2'd2;
    end else if (next_issue_s) begin
      count_r <= 2'd0;
    end else if (head_issue_s) begin
      win_r[0] <= win_r[1];
      count_r  <= count_r - 2'd1;
    end
  end

  // Busy-bit vector; writebacks keep clearing during stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else if (flush) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Issue registers; held while stop is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss0_r <= '0;
      iss1_r <= '0;
    end else if (flush) begin
      iss0_r <= '0;
      iss1_r <= '0;
    end else if (!stop) begin
      iss0_r <= iss0_nxt_s;
      iss1_r <= iss1_nxt_s;
    end
  end

  assign iss0_valid = iss0_r.valid;
  assign iss0_pc    = iss0_r.pc;
  assign iss0_rd    = iss0_r.rd;
  assign iss0_we    = iss0_r.we;
  assign iss1_valid = iss1_r.valid;
  assign iss1_pc    = iss1_r.pc;
  assign iss1_rd    = iss1_r.rd;
  assign iss1_we    = iss1_r.we;
  assign l_flag     = {iss1_r.valid, iss1_r.older, iss0_r.valid, iss0_r.older};

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: stimulus pushes expected issue bundles
// into a queue, a forked monitor pops and compares whenever the DUT issues.
module tb_issue_scoreboard;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ins_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        v0;
    logic [31:0] pc0;
    logic [4:0]  rd0;
    logic        we0;
    logic        v1;
    logic [31:0] pc1;
    logic [4:0]  rd1;
    logic        we1;
    logic [3:0]  lf;
  } exp_t;

  localparam logic [1:0] ALU = 2'b00;
  localparam logic [1:0] MEM = 2'b10;
  localparam logic [1:0] CSR = 2'b11;

  logic        clk, rst, stop, flush, in_valid, in_ready;
  logic [31:0] in1_pc, in2_pc;
  logic [4:0]  in1_rd, in1_rs1, in1_rs2, in2_rd, in2_rs1, in2_rs2;
  logic        in1_use_rs1, in1_use_rs2, in1_we, in2_use_rs1, in2_use_rs2, in2_we;
  logic [1:0]  in1_class, in2_class;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_rd, wb1_rd;
  logic        iss0_valid, iss0_we, iss1_valid, iss1_we;
  logic [31:0] iss0_pc, iss1_pc;
  logic [4:0]  iss0_rd, iss1_rd;
  logic [3:0]  l_flag;

  int   n_checks;
  int   n_fail;
  int   cyc;
  exp_t exp_q[$];

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .stop(stop), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1_pc(in1_pc), .in1_rd(in1_rd), .in1_rs1(in1_rs1), .in1_rs2(in1_rs2),
    .in1_use_rs1(in1_use_rs1), .in1_use_rs2(in1_use_rs2), .in1_we(in1_we), .in1_class(in1_class),
    .in2_pc(in2_pc), .in2_rd(in2_rd), .in2_rs1(in2_rs1), .in2_rs2(in2_rs2),
    .in2_use_rs1(in2_use_rs1), .in2_use_rs2(in2_use_rs2), .in2_we(in2_we), .in2_class(in2_class),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
    .iss0_valid(iss0_valid), .iss0_pc(iss0_pc), .iss0_rd(iss0_rd), .iss0_we(iss0_we),
    .iss1_valid(iss1_valid), .iss1_pc(iss1_pc), .iss1_rd(iss1_rd), .iss1_we(iss1_we),
    .l_flag(l_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ins_t mk(input logic [31:0] pc, input logic [1:0] cls,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{pc: pc, cls: cls, rd: rd, rs1: rs1, rs2: rs2};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int c, input logic v0, input logic [31:0] pc0, input logic [4:0] rd0,
                          input logic v1, input logic [31:0] pc1, input logic [4:0] rd1,
                          input logic [3:0] lf);
    exp_t e;
    e.cyc = 32'(c); e.v0 = v0; e.pc0 = pc0; e.rd0 = rd0; e.we0 = v0;
    e.v1 = v1; e.pc1 = pc1; e.rd1 = rd1; e.we1 = v1; e.lf = lf;
    exp_q.push_back(e);
  endtask

  task automatic wb2(input logic [4:0] r0, input logic [4:0] r1);
    wb0_valid = 1'b1; wb0_rd = r0;
    wb1_valid = 1'b1; wb1_rd = r1;
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
  endtask

  // Presents a pair, waits (bounded) for in_ready, returns the accepting edge number.
  task automatic send_pair(input ins_t a, input ins_t b, output int acc);
    int tries;
    in1_pc = a.pc; in1_class = a.cls; in1_rd = a.rd; in1_rs1 = a.rs1; in1_rs2 = a.rs2;
    in1_use_rs1 = 1'b1; in1_use_rs2 = (a.rs2 != 5'd0); in1_we = 1'b1;
    in2_pc = b.pc; in2_class = b.cls; in2_rd = b.rd; in2_rs1 = b.rs1; in2_rs2 = b.rs2;
    in2_use_rs1 = 1'b1; in2_use_rs2 = (b.rs2 != 5'd0); in2_we = 1'b1;
    in_valid = 1'b1;
    tries = 0;
    #1;
    while (!in_ready && tries < 20) begin
      @(posedge clk);
      #3;
      tries++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout pc=%h in_ready=%b required=1", a.pc, in_ready);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    #1;
  endtask

  task automatic monitor();
    logic upd;
    exp_t got;
    exp_t want;
    forever begin
      @(posedge clk);
      upd = !stop && rst;
      @(negedge clk);
      if (upd && (iss0_valid || iss1_valid)) begin
        got.cyc = 32'(cyc); got.v0 = iss0_valid; got.pc0 = iss0_pc; got.rd0 = iss0_rd;
        got.we0 = iss0_we; got.v1 = iss1_valid; got.pc1 = iss1_pc; got.rd1 = iss1_rd;
        got.we1 = iss1_we; got.lf = l_flag;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_issue cyc=%0d pc0=%h pc1=%h lf=%b", cyc, iss0_pc, iss1_pc, l_flag);
        end else begin
          want = exp_q.pop_front();
          if (got !== want)
            begin
              n_fail++;
              $display("FAIL issue_out actual/expected cyc=%0d/%0d v0=%b/%b pc0=%h/%h rd0=%0d/%0d we0=%b/%b v1=%b/%b pc1=%h/%h rd1=%0d/%0d we1=%b/%b lf=%b/%b",
                       got.cyc, want.cyc, got.v0, want.v0, got.pc0, want.pc0, got.rd0, want.rd0,
                       got.we0, want.we0, got.v1, want.v1, got.pc1, want.pc1, got.rd1, want.rd1,
                       got.we1, want.we1, got.lf, want.lf);
            end
        end
      end
    end
  endtask

  initial begin
    int acc;
    int acc2;
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b0; stop = 1'b0; flush = 1'b0; in_valid = 1'b0;
    wb0_valid = 1'b0; wb0_rd = 5'd0; wb1_valid = 1'b0; wb1_rd = 5'd0;
    in1_pc = 32'd0; in1_rd = 5'd0; in1_rs1 = 5'd0; in1_rs2 = 5'd0; in1_class = 2'b00;
    in1_use_rs1 = 1'b0; in1_use_rs2 = 1'b0; in1_we = 1'b0;
    in2_pc = 32'd0; in2_rd = 5'd0; in2_rs1 = 5'd0; in2_rs2 = 5'd0; in2_class = 2'b00;
    in2_use_rs1 = 1'b0; in2_use_rs2 = 1'b0; in2_we = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outputs", 64'({iss0_valid, iss1_valid, l_flag, iss0_pc | iss1_pc}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    tick();

    // Independent ALU pair co-issues on both pipes
    send_pair(mk(32'h100, ALU, 5'd5, 5'd1, 5'd0), mk(32'h104, ALU, 5'd6, 5'd2, 5'd0), acc);
    push_exp(acc + 1, 1'b1, 32'h100, 5'd5, 1'b1, 32'h104, 5'd6, 4'b1011);
    tick();
    chk("busy_5_6_set", 64'({dut.busy_r[5], dut.busy_r[6]}), 64'd3);
    tick();
    chk("idle_valid_low", 64'({iss0_valid, iss1_valid}), 64'd0);
    wb2(5'd5, 5'd6);
    chk("busy_cleared_t1", 64'(dut.busy_r), 64'd0);

    // RAW on x5 (via rs2): younger waits for wb0 x5
    send_pair(mk(32'h200, ALU, 5'd5, 5'd1, 5'd0), mk(32'h204, ALU, 5'd7, 5'd3, 5'd5), acc);
    push_exp(acc + 1, 1'b1, 32'h200, 5'd5, 1'b0, 32'h0, 5'd0, 4'b0011);
    push_exp(acc + 4, 1'b1, 32'h204, 5'd7, 1'b0, 32'h0, 5'd0, 4'b0011);
    tick();
    tick();
    chk("younger_blocked_ready", 64'(in_ready), 64'd0);
    chk("younger_blocked_valid", 64'(iss0_valid), 64'd0);
    wb0_valid = 1'b1; wb0_rd = 5'd5;
    tick();
    wb0_valid = 1'b0;
    tick();
    wb2(5'd7, 5'd7);

    // MEM,MEM serialises on pipe1; CSR,ALU serialises in order; MEM,ALU co-issues
    send_pair(mk(32'h300, MEM, 5'd10, 5'd2, 5'd0), mk(32'h304, MEM, 5'd11, 5'd3, 5'd0), acc);
    push_exp(acc + 1, 1'b0, 32'h0, 5'd0, 1'b1, 32'h300, 5'd10, 4'b1100);
    push_exp(acc + 2, 1'b0, 32'h0, 5'd0, 1'b1, 32'h304, 5'd11, 4'b1100);
    tick();
    tick();
    wb2(5'd10, 5'd11);
    send_pair(mk(32'h400, CSR, 5'd12, 5'd0, 5'd0), mk(32'h404, ALU, 5'd13, 5'd1, 5'd0), acc);
    push_exp(acc + 1, 1'b1, 32'h400, 5'd12, 1'b0, 32'h0, 5'd0, 4'b0011);
    push_exp(acc + 2, 1'b1, 32'h404, 5'd13, 1'b0, 32'h0, 5'd0, 4'b0011);
    tick();
    tick();
    wb2(5'd12, 5'd13);
    send_pair(mk(32'h500, MEM, 5'd14, 5'd2, 5'd0), mk(32'h504, ALU, 5'd15, 5'd3, 5'd0), acc);
    push_exp(acc + 1, 1'b1, 32'h504, 5'd15, 1'b1, 32'h500, 5'd14, 4'b1110);
    tick();
    wb2(5'd14, 5'd15);
    chk("busy_cleared_t3", 64'(dut.busy_r), 64'd0);

    // Stop with a full window: outputs frozen, wb1 still clears busy
    send_pair(mk(32'h600, ALU, 5'd9, 5'd1, 5'd0), mk(32'h604, MEM, 5'd17, 5'd2, 5'd0), acc);
    push_exp(acc + 1, 1'b1, 32'h600, 5'd9, 1'b1, 32'h604, 5'd17, 4'b1011);
    tick();
    stop = 1'b1;
    send_pair(mk(32'h700, ALU, 5'd18, 5'd1, 5'd0), mk(32'h704, ALU, 5'd19, 5'd2, 5'd0), acc2);
    for (int i = 0; i < 3; i++) begin
      chk("stop_frozen", 64'({iss0_valid, iss0_pc, iss1_valid, iss1_pc[26:0], l_flag}),
          64'({1'b1, 32'h600, 1'b1, 27'h604, 4'b1011}));
      chk("stop_in_ready", 64'(in_ready), 64'd0);
      wb1_valid = (i == 0); wb1_rd = 5'd9;
      tick();
    end
    wb1_valid = 1'b0;
    chk("busy9_cleared_in_stop", 64'(dut.busy_r[9]), 64'd0);
    stop = 1'b0;
    push_exp(acc2 + 4, 1'b1, 32'h700, 5'd18, 1'b1, 32'h704, 5'd19, 4'b1011);
    tick();
    wb2(5'd17, 5'd18);
    wb2(5'd19, 5'd19);

    // Issue-time set beats same-cycle writeback; x0 writebacks are ignored
    send_pair(mk(32'h800, ALU, 5'd8, 5'd1, 5'd0), mk(32'h804, ALU, 5'd20, 5'd2, 5'd0), acc);
    push_exp(acc + 1, 1'b1, 32'h800, 5'd8, 1'b1, 32'h804, 5'd20, 4'b1011);
    wb2(5'd8, 5'd20);
    chk("set_wins", 64'(dut.busy_r), 64'h0010_0100);
    wb2(5'd0, 5'd0);
    chk("wb_x0_nochange", 64'(dut.busy_r), 64'h0010_0100);

    // Flush overrides stop with a full window
    stop = 1'b1;
    send_pair(mk(32'h900, ALU, 5'd21, 5'd1, 5'd0), mk(32'h904, ALU, 5'd22, 5'd2, 5'd0), acc);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(dut.busy_r), 64'd0);
    chk("flush_count", 64'(dut.count_r), 64'd0);
    chk("flush_iss", 64'({iss0_valid, iss1_valid, l_flag}), 64'd0);
    stop = 1'b0;
    tick();
    tick();
    chk("post_flush_idle", 64'({iss0_valid, iss1_valid}), 64'd0);

    // Async reset in the middle of a back-to-back burst
    send_pair(mk(32'hA00, ALU, 5'd23, 5'd1, 5'd0), mk(32'hA04, ALU, 5'd24, 5'd2, 5'd0), acc);
    push_exp(acc + 1, 1'b1, 32'hA00, 5'd23, 1'b1, 32'hA04, 5'd24, 4'b1011);
    send_pair(mk(32'hB00, ALU, 5'd25, 5'd1, 5'd0), mk(32'hB04, ALU, 5'd26, 5'd2, 5'd0), acc2);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({iss0_valid, iss0_rd, iss0_we, iss1_valid, iss1_rd, iss1_we, l_flag,
                                  iss0_pc[15:0], iss1_pc[15:0]}), 64'd0);
    chk("async_rst_busy", 64'(dut.busy_r), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    chk("no_issue_after_rst", 64'({iss0_valid, iss1_valid}), 64'd0);
    chk("window_discarded", 64'(dut.count_r), 64'd0);

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
